axis_stereo_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter merging the left and right AXI-Stream sample channels from the I2S receiver into one stream for a shared, time-multiplexed PDM DAC path.
- Tags every output beat with its source channel.
- Forces release of a stalled grant after a programmable hold limit and counts those events.

---
 rtl/axis_stereo_arbiter.sv | 96 +++++++++
 tb/tb_axis_stereo_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_stereo_arbiter.sv
// axis_stereo_arbiter: packet-locked round-robin merge of left/right AXI-Stream sample channels
// Ports: s_l_axis_* / s_r_axis_* sample inputs, m_axis_* merged output with m_axis_tid source tag
// (0=left, 1=right), timeout_pulse strobes on a forced grant release, timeout_count saturates at 255.
// Define STEREO_PAIR_EN for strict L/R alternation; the default is work-conserving round-robin.
module axis_stereo_arbiter #(
  parameter int DATA_W   = 8,
  parameter int USER_W   = 1,
  parameter int HOLD_MAX = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_l_axis_tdata,
  input  logic              s_l_axis_tvalid,
  output logic              s_l_axis_tready,
  input  logic              s_l_axis_tlast,
  input  logic [USER_W-1:0] s_l_axis_tuser,
  input  logic [DATA_W-1:0] s_r_axis_tdata,
  input  logic              s_r_axis_tvalid,
  output logic              s_r_axis_tready,
  input  logic              s_r_axis_tlast,
  input  logic [USER_W-1:0] s_r_axis_tuser,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [USER_W-1:0] m_axis_tuser,
  output logic              m_axis_tid,
  output logic              timeout_pulse,
  output logic [7:0]        timeout_count
);
  typedef enum logic [1:0] {IDLE, GRANT_L, GRANT_R} state_t;
  state_t            state_q;
  logic              last_q;
  logic [15:0]       hold_q;
  logic [DATA_W-1:0] data_q;
  logic [USER_W-1:0] user_q;
  logic              vld_q, tlast_q, tid_q, pulse_q;
  logic [7:0]        cnt_q;
  logic              out_free, sel_r, vld_x, last_x, acc, timeout, pick_r, pick_any;
  assign out_free        = !vld_q || m_axis_tready;
  assign s_l_axis_tready = state_q == GRANT_L && out_free;
  assign s_r_axis_tready = state_q == GRANT_R && out_free;
  assign sel_r   = state_q == GRANT_R;
  assign vld_x   = sel_r ? s_r_axis_tvalid : s_l_axis_tvalid;
  assign last_x  = sel_r ? s_r_axis_tlast : s_l_axis_tlast;
  assign acc     = (s_l_axis_tvalid && s_l_axis_tready) || (s_r_axis_tvalid && s_r_axis_tready);
  // only an empty granted source ages the grant; downstream backpressure never does
  assign timeout = state_q != IDLE && !vld_x && hold_q == 16'(HOLD_MAX - 1);
  assign pick_any = s_l_axis_tvalid || s_r_axis_tvalid;
`ifdef STEREO_PAIR_EN
  // strict alternation: a silent partner is granted anyway and released by the hold timer
  assign pick_r = !last_q;
`else
  assign pick_r = s_r_axis_tvalid && (!s_l_axis_tvalid || !last_q);
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      hold_q  <= '0;
      data_q  <= '0;
      user_q  <= '0;
      vld_q   <= 1'b0;
      tlast_q <= 1'b0;
      tid_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pulse_q <= timeout;
      if (timeout && cnt_q != 8'hff) cnt_q <= cnt_q + 8'd1;
      if (acc) begin
        data_q  <= sel_r ? s_r_axis_tdata : s_l_axis_tdata;
        user_q  <= sel_r ? s_r_axis_tuser : s_l_axis_tuser;
        tlast_q <= last_x;
        tid_q   <= sel_r;
        vld_q   <= 1'b1;
      end else if (m_axis_tready) vld_q <= 1'b0;
      if (state_q == IDLE) begin
        hold_q <= '0;
        if (pick_any) state_q <= pick_r ? GRANT_R : GRANT_L;
      end else if ((acc && last_x) || timeout) begin
        state_q <= IDLE;
        last_q  <= sel_r;
        hold_q  <= '0;
      end else if (acc) hold_q <= '0;
      else if (!vld_x) hold_q <= hold_q + 16'd1;
    end
  end
  assign m_axis_tdata  = data_q;
  assign m_axis_tvalid = vld_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tid    = tid_q;
  assign timeout_pulse = pulse_q;
  assign timeout_count = cnt_q;
endmodule

// File: tb/tb_axis_stereo_arbiter.sv
// tb_axis_stereo_arbiter: scoreboard bench for axis_stereo_arbiter
module tb_axis_stereo_arbiter;
  typedef struct {logic [7:0] d; logic l; logic u; logic t;} beat_t;
  logic       clk = 0, rst_n = 0;
  logic [7:0] l_data = 0, r_data = 0;
  logic       l_vld = 0, r_vld = 0, l_last = 0, r_last = 0, l_rdy, r_rdy;
  logic [0:0] l_user = 0, r_user = 0, m_user;
  logic [7:0] m_data, t_count;
  logic       m_vld, m_rdy = 1, m_last, m_tid, t_pulse;
  int         checks = 0, errors = 0, cyc = 0, acc_cyc = 0, pulses = 0, pulse_cyc = 0;
  bit         mon_en = 0, rnd_on = 0, r_rdy_seen = 0, stall = 0, open = 0, open_tid = 0;
  logic [10:0] hold_v = 0;
  beat_t      exp_q[$];
  int         out_tid[$], out_cyc[$];
  axis_stereo_arbiter #(.DATA_W(8), .USER_W(1), .HOLD_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_l_axis_tdata(l_data), .s_l_axis_tvalid(l_vld), .s_l_axis_tready(l_rdy),
    .s_l_axis_tlast(l_last), .s_l_axis_tuser(l_user),
    .s_r_axis_tdata(r_data), .s_r_axis_tvalid(r_vld), .s_r_axis_tready(r_rdy),
    .s_r_axis_tlast(r_last), .s_r_axis_tuser(r_user),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_vld), .m_axis_tready(m_rdy),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user), .m_axis_tid(m_tid),
    .timeout_pulse(t_pulse), .timeout_count(t_count));
  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_on) m_rdy = $urandom_range(0, 9) < 7;
  end
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask
  task automatic set_src(input bit ch, input bit v, input logic [7:0] d, input bit l, input bit u);
    if (ch) begin
      r_vld = v; r_data = d; r_last = l; r_user = u;
    end else begin
      l_vld = v; l_data = d; l_last = l; l_user = u;
    end
  endtask
  task automatic send_beat(input bit ch, input logic [7:0] d, input bit l, input bit u);
    bit fire = 0;
    int n = 0;
    set_src(ch, 1, d, l, u);
    while (!fire && n < 300) begin
      @(negedge clk);
      fire = ch ? (r_vld && r_rdy) : (l_vld && l_rdy);
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!fire) begin
      errors++;
      $display("FAIL handshake ch%0d: got tready 0 for %0d cycles, required 1", ch, n);
    end else begin
      exp_q.push_back('{d, l, u, ch});
      acc_cyc = cyc;
    end
    set_src(ch, 0, 0, 0, 0);
  endtask
  task automatic drive_ch(input bit ch, input int np, input int lmin, input int lmax,
                          input int gmax, input logic [7:0] base, input logic [7:0] step);
    logic [7:0] d = base;
    int len;
    for (int p = 0; p < np; p++) begin
      len = $urandom_range(lmin, lmax);
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, gmax)) begin
          @(posedge clk);
          #1;
        end
        send_beat(ch, d, b == len - 1, 1'($urandom));
        d += step;
      end
    end
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (!rst_n || !mon_en) begin
      stall = 0;
      open = 0;
    end else begin
      if (r_rdy) r_rdy_seen = 1;
      if (stall) begin
        checks++;
        if (!m_vld || {m_data, m_last, m_user, m_tid} != hold_v) begin
          errors++;
          $display("FAIL stable: got valid=%0b beat=%h, required valid=1 beat=%h", m_vld, {m_data, m_last, m_user, m_tid}, hold_v);
        end
      end
      if (t_pulse) begin
        pulses++;
        pulse_cyc = cyc;
        open = 0;
      end
      if (m_vld && m_rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got data=%h tid=%0d, required no beat", m_data, m_tid);
        end else begin
          e = exp_q.pop_front();
          if (m_data != e.d || m_last != e.l || m_user != e.u || m_tid != e.t) begin
            errors++;
            $display("FAIL beat: got d=%h l=%0b u=%0b tid=%0b, required d=%h l=%0b u=%0b tid=%0b", m_data, m_last, m_user, m_tid, e.d, e.l, e.u, e.t);
          end
        end
        if (open) begin
          checks++;
          if (m_tid != open_tid) begin
            errors++;
            $display("FAIL packet_lock: got tid=%0b, required tid=%0b", m_tid, open_tid);
          end
        end
        open = !m_last;
        open_tid = m_tid;
        out_tid.push_back(int'(m_tid));
        out_cyc.push_back(cyc);
      end
      stall = m_vld && !m_rdy;
      hold_v = {m_data, m_last, m_user, m_tid};
    end
  end
  initial begin
    int s, a, n;
    #2;
    chk("rst_m_valid", m_vld, 0);
    chk("rst_l_ready", l_rdy, 0);
    chk("rst_r_ready", r_rdy, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_tid", m_tid, 0);
    chk("rst_pulse", t_pulse, 0);
    chk("rst_count", t_count, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    mon_en = 1;
    // alternation: both sources always valid, single-beat packets
    out_tid.delete(); out_cyc.delete();
    s = cyc;
    fork
      drive_ch(0, 4, 1, 1, 0, 8'h11, 8'h00);
      drive_ch(1, 4, 1, 1, 0, 8'h22, 8'h00);
    join
    drain();
    chk("alt_count", out_tid.size(), 8);
    if (out_cyc.size() > 0) chk("alt_first_latency", out_cyc[0] - s, 2);
    for (int i = 0; i < out_tid.size(); i++) begin
      chk("alt_tid", out_tid[i], i % 2);
      if (i > 0) chk("alt_spacing", out_cyc[i] - out_cyc[i-1], 2);
    end
    // single requester
    out_tid.delete(); r_rdy_seen = 0;
    drive_ch(0, 3, 1, 1, 2, 8'h30, 8'h01);
    drain();
    chk("single_count", out_tid.size(), 3);
    foreach (out_tid[i]) chk("single_tid", out_tid[i], 0);
    chk("single_r_ready_seen", r_rdy_seen, 0);
    // packet lock: left served last, so right leads, then 4 contiguous left beats
    out_tid.delete();
    fork
      drive_ch(0, 1, 4, 4, 0, 8'hA0, 8'h01);
      drive_ch(1, 2, 1, 1, 0, 8'hB0, 8'h01);
    join
    drain();
    chk("lock_count", out_tid.size(), 6);
    if (out_tid.size() == 6) begin
      chk("lock_tid0", out_tid[0], 1);
      for (int i = 1; i < 5; i++) chk("lock_tid_left", out_tid[i], 0);
      chk("lock_tid5", out_tid[5], 1);
    end
    // backpressure longer than the hold limit must not trigger a timeout
    pulses = 0;
    m_rdy = 0;
    fork
      drive_ch(0, 1, 3, 3, 0, 8'hC0, 8'h01);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!m_vld && n < 20);
        chk("bp_valid_seen", m_vld, 1);
        repeat (20) begin
          chk("bp_data", m_data, 8'hC0);
          chk("bp_l_ready", l_rdy, 0);
          chk("bp_pulse", t_pulse, 0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        m_rdy = 1;
      end
    join
    drain();
    chk("bp_pulses", pulses, 0);
    chk("bp_count", t_count, 0);
    // timeout: left stalls mid-packet, right waits
    out_tid.delete(); pulses = 0;
    send_beat(0, 8'hD0, 0, 0);
    a = acc_cyc;
    send_beat(1, 8'hD1, 1, 0);
    drain();
    chk("to_pulses", pulses, 1);
    chk("to_pulse_delay", pulse_cyc - a, 16);
    chk("to_count", t_count, 1);
    chk("to_out_count", out_tid.size(), 2);
    if (out_tid.size() == 2) chk("to_next_tid", out_tid[1], 1);
    // randomized traffic with random backpressure, gaps well under the hold limit
    pulses = 0;
    rnd_on = 1;
    fork
      drive_ch(0, 12, 1, 4, 5, 8'h00, 8'h01);
      drive_ch(1, 12, 1, 4, 5, 8'h80, 8'h01);
    join
    rnd_on = 0;
    m_rdy = 1;
    drain();
    chk("rnd_pulses", pulses, 0);
    chk("rnd_count", t_count, 1);
    // asynchronous reset mid-packet
    mon_en = 0;
    set_src(0, 1, 8'hE0, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_vld && n < 20);
    chk("ar_valid_before", m_vld, 1);
    #1 rst_n = 0;
    #1;
    chk("ar_m_valid", m_vld, 0);
    chk("ar_l_ready", l_rdy, 0);
    chk("ar_r_ready", r_rdy, 0);
    chk("ar_count", t_count, 0);
    set_src(0, 0, 0, 0, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    mon_en = 1;
    out_tid.delete();
    fork
      send_beat(0, 8'hF0, 1, 0);
      send_beat(1, 8'hF1, 1, 1);
    join
    drain();
    chk("ar_out_count", out_tid.size(), 2);
    if (out_tid.size() == 2) begin
      chk("ar_first_tid", out_tid[0], 0);
      chk("ar_second_tid", out_tid[1], 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
